riscv_multicycle_ctrl: RTL
==========================

Name: riscv_multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32 subset datapath (PC register, regfile, immediate generator, ALU, branch/jump muxes). It fetches over a req/ack instruction-memory handshake and latches the instruction into an internal IR that drives the datapath `instr` bus. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB, driving all datapath control lines and gating PC update to exactly one cycle per instruction. It also traps on illegal encodings and counts retired instructions.

Parameters:
NOP_INSTR, 32'h00000013, IR value after reset (addi x0,x0,0)
INSTRET_W, 32, width of retired-instruction counter

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  instruction fetch request (address = datapath pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
dmem_req  out  1  data access request (address = datapath aluOut)
dmem_we  out  1  1 = store (memwrite), 0 = load (memread)
dmem_ack  in  1  data access complete; load data valid at datapath this cycle
instr  out  32  IR contents to datapath
zero  in  1  datapath ALU zero flag
lsb_aluresult  in  1  datapath ALU result bit 0 (SLT outcome)
pc_we  out  1  PC register load enable (one cycle per retired instruction)
regwrite, memtoreg, alusrcA, alusrcB, jump, selBranch  out  1 each  datapath controls
aluControl  out  4  ALU op: 0 AND, 1 OR, 2 ADD, 10 SUB, 11 SLT
trap  out  1  sticky illegal-instruction flag
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (async, immediate): state=FETCH, IR=NOP_INSTR, trap=0, instret=0. All request, enable and control outputs are 0. Any in-flight handshake is abandoned.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding comes from the package.
- FETCH: imem_req=1 until imem_ack. Ack may arrive in the same cycle as req (zero-wait). On ack, IR<=imem_rdata and go to DECODE.
- DECODE: one cycle; regfile read ports settle. If the opcode is illegal: trap<=1, go to HALT.
- HALT: all outputs idle and the PC frozen. Left only by reset.
- EXEC by class:
  - R-type (0110011): alusrcA=1, alusrcB=0. ALU op by funct3/funct7: add, sub, slt, and, or. Go to WB.
  - addi (0010011, f3=000): alusrcA=1, alusrcB=1, ADD. Go to WB.
  - lw (0000011, f3=010) / sw (0100011, f3=010): alusrcA=1, alusrcB=1, ADD. Go to MEM.
  - branch (1100011): alusrcA=1, alusrcB=0.
    - beq: SUB, taken=zero. bne: SUB, taken=!zero. blt: SLT, taken=lsb_aluresult.
    - selBranch=taken, pc_we=1, instret++, go to FETCH.
  - jal (1101111): alusrcA=0 (pc), alusrcB=1, ADD, jump=1, pc_we=1, instret++, go to FETCH. rd is not written (no link path).
- MEM: EXEC controls held so aluOut stays stable; dmem_req=1 and dmem_we=(sw) until dmem_ack.
  - On ack, lw goes to WB.
  - On ack, sw asserts pc_we=1, instret++, and goes to FETCH.
- WB: EXEC ALU controls held. regwrite=1 for exactly this one cycle; memtoreg=1 only for lw. pc_we=1, instret++, go to FETCH.
- Any other funct3/funct7 combination is illegal.
- Zero-wait cycle counts: R/addi 4, lw 5, sw 4, branch/jal 3.
- Acks arriving when the matching req=0 are ignored.
- Control outputs are decoded from state and IR only. The single exception is selBranch in EXEC, which also depends on zero/lsb_aluresult.
- rd=x0 writes are issued as normal; the regfile ignores them.
- instret wraps modulo 2^INSTRET_W.
- pc_we never asserts in FETCH, DECODE or HALT, and never more than once per instruction.

Decomposition:
- Package riscv_ctrl_pkg:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL)
  - funct3 constants
  - ALU codes (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=10, ALU_SLT=11)
  - state encoding
- One combinational sub-module, riscv_instr_decode: IR -> instruction class, ALU code, alusrcA/alusrcB, illegal flag. The FSM stays in riscv_multicycle_ctrl.

Test Plan:
- Zero-wait fetch of 32'h00500113 (addi x2,x0,5) -> states F,D,E,WB. regwrite=1 and pc_we=1 in cycle 4 only. aluControl=2, alusrcB=1, instret=1.
- lw 32'h00402483 with dmem_ack delayed 2 cycles -> dmem_req=1, dmem_we=0 held 3 cycles. WB has memtoreg=1, regwrite=1. pc_we pulses once; total 7 cycles.
- beq 32'h00720463:
  - zero=1 -> EXEC has aluControl=10, selBranch=1, pc_we=1.
  - zero=0 -> selBranch=0, pc_we=1.
  - regwrite stays 0 in both cases.
- blt 32'h00314263 with lsb_aluresult=1 -> aluControl=11, selBranch=1.
- jal 32'hFFDFF06F -> alusrcA=0, alusrcB=1, jump=1, pc_we=1 in EXEC, regwrite=0.
- Illegal 32'hFFFFFFFF -> trap=1 after DECODE. No further imem_req or pc_we.
- Reset asserted mid-MEM -> all outputs 0 asynchronously, IR=32'h00000013, trap=0, instret=0. A late dmem_ack is ignored.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 subset controller.
package riscv_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ALU_W  = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [ALU_W-1:0] ALU_AND = 4'd0;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'd10;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'd11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_R      = 3'd0,
        CL_ADDI   = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4,
        CL_JAL    = 3'd5
    } iclass_t;

    typedef enum logic [1:0] {
        BR_EQ = 2'd0,
        BR_NE = 2'd1,
        BR_LT = 2'd2
    } br_t;

    // Decoded view of the IR consumed by the sequencer.
    typedef struct packed {
        iclass_t          iclass;
        br_t              br;
        logic [ALU_W-1:0] alu_op;
        logic             alusrc_a;
        logic             alusrc_b;
        logic             illegal;
    } dec_t;

endpackage

// File: rtl/riscv_instr_decode.sv
// Combinational IR field decode: class, ALU op, operand selects, illegal flag.
module riscv_instr_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output dec_t       dec
);

    // Anything not explicitly recognised below stays flagged illegal.
    always_comb begin
        dec          = '0;
        dec.iclass   = CL_R;
        dec.br       = BR_EQ;
        dec.alu_op   = ALU_ADD;
        dec.illegal  = 1'b1;
        case (opcode)
            OP_R: begin
                dec.iclass   = CL_R;
                dec.alusrc_a = 1'b1;
                if (funct7 == F7_BASE) begin
                    dec.illegal = 1'b0;
                    case (funct3)
                        F3_ADD_SUB: dec.alu_op = ALU_ADD;
                        F3_SLT:     dec.alu_op = ALU_SLT;
                        F3_OR:      dec.alu_op = ALU_OR;
                        F3_AND:     dec.alu_op = ALU_AND;
                        default:    dec.illegal = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    dec.illegal = 1'b0;
                    dec.alu_op  = ALU_SUB;
                end
            end
            OP_IMM: begin
                dec.iclass   = CL_ADDI;
                dec.alusrc_a = 1'b1;
                dec.alusrc_b = 1'b1;
                dec.illegal  = (funct3 != F3_ADD_SUB);
            end
            OP_LOAD: begin
                dec.iclass   = CL_LOAD;
                dec.alusrc_a = 1'b1;
                dec.alusrc_b = 1'b1;
                dec.illegal  = (funct3 != F3_WORD);
            end
            OP_STORE: begin
                dec.iclass   = CL_STORE;
                dec.alusrc_a = 1'b1;
                dec.alusrc_b = 1'b1;
                dec.illegal  = (funct3 != F3_WORD);
            end
            OP_BRANCH: begin
                dec.iclass   = CL_BRANCH;
                dec.alusrc_a = 1'b1;
                dec.illegal  = 1'b0;
                case (funct3)
                    F3_BEQ: begin dec.br = BR_EQ; dec.alu_op = ALU_SUB; end
                    F3_BNE: begin dec.br = BR_NE; dec.alu_op = ALU_SUB; end
                    F3_BLT: begin dec.br = BR_LT; dec.alu_op = ALU_SLT; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.iclass   = CL_JAL;
                dec.alusrc_b = 1'b1;
                dec.illegal  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 subset datapath.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
    parameter int unsigned     INSTRET_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [XLEN-1:0]      imem_rdata,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic [XLEN-1:0]      instr,
    input  logic                 zero,
    input  logic                 lsb_aluresult,
    output logic                 pc_we,
    output logic                 regwrite,
    output logic                 memtoreg,
    output logic                 alusrcA,
    output logic                 alusrcB,
    output logic                 jump,
    output logic                 selBranch,
    output logic [ALU_W-1:0]     aluControl,
    output logic                 trap,
    output logic [INSTRET_W-1:0] instret
);

    state_t state;
    dec_t   dec;
    logic   taken;

    riscv_instr_decode u_decode (
        .opcode (instr[6:0]),
        .funct3 (instr[14:12]),
        .funct7 (instr[31:25]),
        .dec    (dec)
    );

    // Branch outcome from the live ALU flags.
    always_comb begin
        taken = 1'b0;
        case (dec.br)
            BR_EQ:   taken = zero;
            BR_NE:   taken = ~zero;
            BR_LT:   taken = lsb_aluresult;
            default: taken = 1'b0;
        endcase
    end

    // Sequencer state, IR, sticky trap and retire counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_FETCH;
            instr   <= NOP_INSTR;
            trap    <= 1'b0;
            instret <= '0;
        end else begin
            if (pc_we) begin
                instret <= instret + INSTRET_W'(1);
            end
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec.illegal) begin
                        trap  <= 1'b1;
                        state <= ST_HALT;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (dec.iclass)
                        CL_LOAD, CL_STORE:  state <= ST_MEM;
                        CL_BRANCH, CL_JAL:  state <= ST_FETCH;
                        default:            state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        state <= (dec.iclass == CL_STORE) ? ST_FETCH : ST_WB;
                    end
                end
                ST_WB:   state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Datapath controls decoded from state and IR; forced idle while in reset.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_we      = 1'b0;
        regwrite   = 1'b0;
        memtoreg   = 1'b0;
        alusrcA    = 1'b0;
        alusrcB    = 1'b0;
        jump       = 1'b0;
        selBranch  = 1'b0;
        aluControl = ALU_AND;
        if (!reset) begin
            case (state)
                ST_FETCH: imem_req = 1'b1;
                ST_EXEC: begin
                    alusrcA    = dec.alusrc_a;
                    alusrcB    = dec.alusrc_b;
                    aluControl = dec.alu_op;
                    if (dec.iclass == CL_BRANCH) begin
                        selBranch = taken;
                        pc_we     = 1'b1;
                    end
                    if (dec.iclass == CL_JAL) begin
                        jump  = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                ST_MEM: begin
                    alusrcA    = dec.alusrc_a;
                    alusrcB    = dec.alusrc_b;
                    aluControl = dec.alu_op;
                    dmem_req   = 1'b1;
                    dmem_we    = (dec.iclass == CL_STORE);
                    pc_we      = (dec.iclass == CL_STORE) && dmem_ack;
                end
                ST_WB: begin
                    alusrcA    = dec.alusrc_a;
                    alusrcB    = dec.alusrc_b;
                    aluControl = dec.alu_op;
                    regwrite   = 1'b1;
                    memtoreg   = (dec.iclass == CL_LOAD);
                    pc_we      = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
